// File: rtl/down_timer_pkg.sv
// Shared types and defaults for the loadable down-counting timer.
package down_timer_pkg;
   typedef enum logic {IDLE, RUN} timer_state_e;
   localparam int DEFAULT_WIDTH = 5;
endpackage

// File: rtl/down_timer.sv
// Loadable, enabled down-counter with one-shot or periodic terminal-count tick.
module down_timer
   import down_timer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             in_enable,
   input  logic             in_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             in_start,
   input  logic             in_periodic,
   output logic [WIDTH-1:0] o_count,
   output logic             o_busy,
   output logic             o_tick
);

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   timer_state_e     r_state, w_state_next;
   logic [WIDTH-1:0] r_count, w_count_next;
   logic [WIDTH-1:0] r_reload, w_reload_next;
   logic             r_tick, w_tick_next;
   logic             r_busy;

   always_comb begin
      w_state_next  = r_state;
      w_count_next  = r_count;
      w_reload_next = r_reload;
      w_tick_next   = 1'b0;

      if (in_load) begin
         w_reload_next = i_data;
         w_count_next  = i_data;
         w_state_next  = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_start && (r_reload != ZERO)) begin
                  w_count_next = r_reload;
                  w_state_next = RUN;
               end
            end
            RUN: begin
               if (in_enable) begin
                  if (r_count == ONE) begin
                     w_tick_next = 1'b1;
                     if (in_periodic) begin
                        w_count_next = r_reload;
                     end else begin
                        w_count_next = ZERO;
                        w_state_next = IDLE;
                     end
                  end else if (r_count != ZERO) begin
                     // Never decrement from zero, so no wrap can occur.
                     w_count_next = r_count - ONE;
                  end else begin
                     w_state_next = IDLE;
                  end
               end
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_count  <= ZERO;
         r_reload <= ZERO;
         r_tick   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_count  <= w_count_next;
         r_reload <= w_reload_next;
         r_tick   <= w_tick_next;
         r_busy   <= (w_state_next == RUN);
      end
   end

   assign o_count = r_count;
   assign o_busy  = r_busy;
   assign o_tick  = r_tick;

endmodule
